// File: rtl/gbe_tx_arb_pkg.sv
// Shared types and widths for the 10GbE transmit arbiter.
package gbe_tx_arb_pkg;

    localparam int WORD_W = 64;
    localparam int IP_W   = 32;
    localparam int PORT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: the first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/gbe_tx_arbiter.sv
// Round-robin packet arbiter feeding the 10GbE core; oversize frames are cut and the tail dropped.
// Define GBE_TX_ARB_STATS_EN to add per-requester pkt_count outputs.
module gbe_tx_arbiter
    import gbe_tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [WORD_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_eof,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [IP_W*NUM_REQ-1:0]    cfg_dest_ip,
    input  logic [PORT_W*NUM_REQ-1:0]  cfg_dest_port,
    output logic                       tx_valid,
    output logic                       tx_end_of_frame,
    output logic [WORD_W-1:0]          tx_data,
    output logic [IP_W-1:0]            tx_dest_ip,
    output logic [PORT_W-1:0]          tx_dest_port,
    input  logic                       tx_afull,
    input  logic                       tx_overflow,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       len_err,
    output logic                       ovf_err
`ifdef GBE_TX_ARB_STATS_EN
    ,
    output logic [32*NUM_REQ-1:0]      pkt_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, owner;
    logic [CNT_W-1:0]   word_cnt;
    logic [NUM_REQ-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;
    logic               accept, own_valid, own_eof, last_slot;
    logic [WORD_W-1:0]  own_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    assign own_valid = req_valid[owner];
    assign own_eof   = req_eof[owner];
    assign own_data  = req_data[owner*WORD_W +: WORD_W];
    assign last_slot = (word_cnt == CNT_W'(MAX_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: if (rr_any) state_nxt = XFER;
            XFER: begin
                req_ready = grant & {NUM_REQ{!tx_afull}};
                accept    = own_valid && !tx_afull;
                if (accept) begin
                    if (own_eof)        state_nxt = IDLE;
                    else if (last_slot) state_nxt = DROP;
                end
            end
            // tail of an oversize frame is swallowed even while the core is backpressuring
            DROP: begin
                req_ready = grant;
                accept    = own_valid;
                if (accept && own_eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant           <= '0;
            owner           <= '0;
            ptr             <= '0;
            word_cnt        <= '0;
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            tx_data         <= '0;
            tx_dest_ip      <= '0;
            tx_dest_port    <= '0;
            len_err         <= 1'b0;
            ovf_err         <= 1'b0;
        end else begin
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            if (tx_overflow) ovf_err <= 1'b1;
            case (state)
                IDLE: if (rr_any) begin
                    grant        <= rr_grant;
                    owner        <= rr_idx;
                    ptr          <= (rr_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
                    tx_dest_ip   <= cfg_dest_ip[rr_idx*IP_W +: IP_W];
                    tx_dest_port <= cfg_dest_port[rr_idx*PORT_W +: PORT_W];
                    word_cnt     <= '0;
                end
                XFER: if (accept) begin
                    tx_valid        <= 1'b1;
                    tx_data         <= own_data;
                    tx_end_of_frame <= own_eof || last_slot;
                    word_cnt        <= word_cnt + 1'b1;
                    if (!own_eof && last_slot) len_err <= 1'b1;
                    if (own_eof) grant <= '0;
                end
                DROP: if (accept && own_eof) grant <= '0;
                default: ;
            endcase
        end
    end

`ifdef GBE_TX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            pkt_count <= '0;
        else if (state == XFER && accept && (own_eof || last_slot))
            pkt_count[owner*32 +: 32] <= pkt_count[owner*32 +: 32] + 32'd1;
    end
`endif

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// Randomised bench for gbe_tx_arbiter against a transaction-level frame/arbitration model.
module tb_gbe_tx_arbiter;

    localparam int NR   = 4;
    localparam int MAXW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_eof, req_ready, grant;
    logic [64*NR-1:0]  req_data;
    logic [32*NR-1:0]  cfg_dest_ip;
    logic [16*NR-1:0]  cfg_dest_port;
    logic              tx_valid, tx_end_of_frame, tx_afull, tx_overflow, len_err, ovf_err;
    logic [63:0]       tx_data;
    logic [31:0]       tx_dest_ip;
    logic [15:0]       tx_dest_port;
`ifdef GBE_TX_ARB_STATS_EN
    logic [32*NR-1:0]  pkt_count;
`endif

    gbe_tx_arbiter #(.NUM_REQ(NR), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_eof(req_eof), .req_ready(req_ready),
        .cfg_dest_ip(cfg_dest_ip), .cfg_dest_port(cfg_dest_port),
        .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame), .tx_data(tx_data),
        .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
        .tx_afull(tx_afull), .tx_overflow(tx_overflow),
        .grant(grant), .len_err(len_err), .ovf_err(ovf_err)
`ifdef GBE_TX_ARB_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // stimulus knobs
    logic [NR-1:0] mask;
    int vprob, aprob, rprob, oprob;
    int len_cfg[NR];
    // per-requester packet sources
    int pos[NR], len[NR], left[NR], pid[NR];
    logic [31:0] salt[NR];
    // inputs as presented before the next edge
    logic          pv_rst, pv_ovf;
    logic [NR-1:0] pv_valid, pv_eof, pv_ready;
    logic [63:0]   pv_data[NR];
    logic [31:0]   pv_ip[NR];
    logic [15:0]   pv_port[NR];
    // reference model
    int          m_owner, m_last, m_cnt;
    bit          m_drop, m_len, m_ovf;
    logic [31:0] m_ip;
    logic [15:0] m_port;
    int unsigned m_pkts[NR];
    logic [31:0] order_code;
    int          n_txw;

    function automatic int new_len(int i);
        return (len_cfg[i] == 0) ? int'($urandom_range(1, 20)) : len_cfg[i];
    endfunction

    task automatic next_packet(int i);
        pos[i]  = 0;
        pid[i]  = pid[i] + 1;
        len[i]  = new_len(i);
        salt[i] = $urandom;
    endtask

    task automatic check_edge();
        bit          exp_valid, exp_eof;
        logic [63:0] exp_data;
        int          o;
        exp_valid = 0; exp_eof = 0; exp_data = '0;
        if (tx_valid === 1'b1) n_txw++;
        if (pv_rst) begin
            m_owner = -1; m_last = NR - 1; m_drop = 0; m_len = 0; m_ovf = 0;
            m_ip = '0; m_port = '0;
            for (int i = 0; i < NR; i++) begin m_pkts[i] = 0; pos[i] = 0; end
            chk("rst_data", tx_data, 64'd0);
        end else begin
            if (m_owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int idx = (m_last + k) % NR;
                    if (m_owner < 0 && pv_valid[idx]) m_owner = idx;
                end
                if (m_owner >= 0) begin
                    m_last = m_owner; m_cnt = 0; m_drop = 0;
                    m_ip = pv_ip[m_owner]; m_port = pv_port[m_owner];
                    order_code = {order_code[27:0], 4'(m_owner + 1)};
                end
            end else begin
                o = m_owner;
                if (pv_valid[o] && pv_ready[o]) begin
                    if (!m_drop) begin
                        exp_valid = 1;
                        exp_data  = pv_data[o];
                        m_cnt++;
                        exp_eof = pv_eof[o] || (m_cnt == MAXW);
                        if (exp_eof) m_pkts[o]++;
                        if (m_cnt == MAXW && !pv_eof[o]) begin m_drop = 1; m_len = 1; end
                    end
                    if (pv_eof[o]) begin
                        left[o]--;
                        next_packet(o);
                        m_owner = -1;
                    end else begin
                        pos[o]++;
                    end
                end
            end
            if (pv_ovf) m_ovf = 1;
        end
        chk("tx_valid", 64'(tx_valid), 64'(exp_valid));
        chk("tx_eof", 64'(tx_end_of_frame), 64'(exp_eof));
        if (exp_valid) chk("tx_data", tx_data, exp_data);
        chk("grant", 64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
        chk("dest_ip", 64'(tx_dest_ip), 64'(m_ip));
        chk("dest_port", 64'(tx_dest_port), 64'(m_port));
        chk("len_err", 64'(len_err), 64'(m_len));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
`ifdef GBE_TX_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("pkt_count", 64'(pkt_count[i*32 +: 32]), 64'(m_pkts[i]));
`endif
    endtask

    task automatic drive();
        bit v;
        rst = ($urandom_range(999) < rprob);
        for (int i = 0; i < NR; i++) begin
            v = mask[i] && left[i] > 0 && ($urandom_range(99) < vprob);
            req_valid[i] = v;
            req_eof[i]   = v && (pos[i] == len[i] - 1);
            req_data[i*64 +: 64] = {8'(i), 8'(pid[i]), 16'(pos[i]), salt[i]};
            if ($urandom_range(99) < 5) begin
                cfg_dest_ip[i*32 +: 32]   = $urandom;
                cfg_dest_port[i*16 +: 16] = 16'($urandom);
            end
            pv_data[i] = req_data[i*64 +: 64];
            pv_ip[i]   = cfg_dest_ip[i*32 +: 32];
            pv_port[i] = cfg_dest_port[i*16 +: 16];
        end
        tx_afull    = ($urandom_range(99) < aprob);
        tx_overflow = ($urandom_range(999) < oprob);
        pv_rst = rst; pv_ovf = tx_overflow; pv_valid = req_valid; pv_eof = req_eof;
        #1;
    endtask

    task automatic check_ready();
        logic [NR-1:0] e;
        e = '0;
        if (m_owner >= 0 && (m_drop || !tx_afull)) e = NR'(1 << m_owner);
        chk("req_ready", 64'(req_ready), 64'(e));
        pv_ready = req_ready;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk); #1;
            check_edge();
            drive();
            check_ready();
        end
    endtask

    task automatic reset_and_setup(logic [NR-1:0] msk, int plen0, int plen1, int plen2, int plen3, int pkts);
        mask = '0; rprob = 1000;
        run(2);
        rprob = 0;
        len_cfg[0] = plen0; len_cfg[1] = plen1; len_cfg[2] = plen2; len_cfg[3] = plen3;
        for (int i = 0; i < NR; i++) begin
            left[i] = pkts; pos[i] = 0; len[i] = new_len(i); salt[i] = $urandom;
        end
        mask = msk; order_code = '0; n_txw = 0;
    endtask

    initial begin
        cfg_dest_ip = '0; cfg_dest_port = '0;
        for (int i = 0; i < NR; i++) begin
            cfg_dest_ip[i*32 +: 32]   = 32'h0a00_0000 + 32'(i);
            cfg_dest_port[i*16 +: 16] = 16'(1000 + i);
            pid[i] = 0; left[i] = 0; pos[i] = 0; len[i] = 1; len_cfg[i] = 0; salt[i] = '0;
        end
        m_owner = -1; m_last = NR - 1; m_cnt = 0; m_drop = 0; m_len = 0; m_ovf = 0;
        m_ip = '0; m_port = '0; order_code = '0; n_txw = 0;
        for (int i = 0; i < NR; i++) m_pkts[i] = 0;
        mask = '0; vprob = 100; aprob = 0; oprob = 0; rprob = 1000;
        drive();
        pv_ready = req_ready;

        // requesters 0 and 2 with 4-word packets from the same cycle
        reset_and_setup(4'b0101, 4, 4, 4, 4, 1);
        vprob = 100; aprob = 0; oprob = 0;
        run(20);
        chk("p037_order", 64'(order_code), 64'h13);
        chk("p037_drain", 64'(left[0] + left[2]), 64'd0);

        // all four continuously valid with 1-word packets: strict rotation
        reset_and_setup(4'b1111, 1, 1, 1, 1, 2);
        run(24);
        chk("p038_order", 64'(order_code), 64'h1234_1234);

        // 8-word frame with a 5-cycle backpressure window mid-frame
        reset_and_setup(4'b0001, 8, 8, 8, 8, 1);
        run(4);
        aprob = 100;
        run(5);
        aprob = 0;
        run(12);
        chk("p039_words", 64'(n_txw), 64'd8);
        chk("p039_drain", 64'(left[0]), 64'd0);

        // oversize 20-word frame is cut at 16, then requester 1 is served
        reset_and_setup(4'b0011, 20, 3, 1, 1, 1);
        run(40);
        chk("p040_order", 64'(order_code), 64'h12);
        chk("p040_words", 64'(n_txw), 64'd19);
        chk("p040_len_err", 64'(len_err), 64'd1);

        // random traffic with backpressure, overflow pulses, config churn and resets
        reset_and_setup(4'b1111, 0, 0, 0, 0, 10000);
        vprob = 70; aprob = 25; oprob = 2; rprob = 3;
        run(3000);
        rprob = 0; oprob = 0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gbe_tx_arbiter.md
GBE_TX_ARBITER -- requirements
Module: gbe_tx_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning); all ports below are listed name, direction, width, meaning, with clock and reset first.
REQ-002 NUM_REQ, 4, number of packet requesters (2..8).
REQ-003 MAX_WORDS, 1024, maximum 64-bit words per frame.
REQ-004 clk  in  1  single clock, shared with the 10GbE core fabric side.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester word valid.
REQ-007 req_data  in  64*NUM_REQ  per-requester word; requester i occupies bits [64i+63:64i].
REQ-008 req_eof  in  NUM_REQ  last word of packet, qualified by req_valid.
REQ-009 req_ready  out  NUM_REQ  word accepted when req_valid and req_ready are both high.
REQ-010 cfg_dest_ip  in  32*NUM_REQ  per-requester destination IP.
REQ-011 cfg_dest_port  in  16*NUM_REQ  per-requester destination UDP port.
REQ-012 tx_valid, tx_end_of_frame  out  1 each  to the 10GbE core.
REQ-013 tx_data  out  64;  tx_dest_ip  out  32;  tx_dest_port  out  16.
REQ-014 tx_afull, tx_overflow  in  1 each  from the 10GbE core.
REQ-015 grant  out  NUM_REQ  one-hot current owner; all zero when idle.
REQ-016 len_err, ovf_err  out  1 each  sticky error flags.

Function
REQ-017 States: IDLE, XFER, DROP.
REQ-018 IDLE: the lowest-index requester with req_valid, searched round-robin starting after the last owner, SHALL be granted; the state moves to XFER on the next cycle, and grant, tx_dest_ip and tx_dest_port SHALL latch that requester's config in the same cycle.
REQ-019 Config changes during a packet SHALL NOT affect that packet.
REQ-020 XFER: req_ready[owner] = !tx_afull; all other req_ready bits SHALL be 0.
REQ-021 Each accepted word SHALL appear on tx_data, tx_valid and tx_end_of_frame exactly 1 cycle later (registered); tx_valid SHALL be 0 otherwise.
REQ-022 An accepted eof SHALL return the block to IDLE; the next grant is possible the cycle after, giving a 1 idle cycle minimum between frames.
REQ-023 The word counter SHALL count accepted words in the frame. When word MAX_WORDS is accepted without eof, that word SHALL be output with tx_end_of_frame=1, len_err SHALL set, and the state SHALL move to DROP.
REQ-024 DROP: req_ready[owner]=1 regardless of tx_afull; words SHALL be discarded (tx_valid=0) until eof is accepted; then the state returns to IDLE.
REQ-025 tx_afull asserting mid-packet SHALL stall the transfer without breaking the frame; the grant is held.
REQ-026 A requester deasserting req_valid mid-packet SHALL hold the grant; no timeout.
REQ-027 eof on the MAX_WORDS-th word SHALL be a normal end of frame, with no len_err.
REQ-028 tx_overflow=1 in any cycle SHALL set ovf_err.
REQ-029 The round-robin pointer SHALL update only when a grant is issued.

Reset
REQ-030 rst SHALL be synchronous and active-high, with priority over all other behaviour.
REQ-031 Reset values: state IDLE; grant 0; req_ready 0; tx_valid 0; tx_end_of_frame 0; tx_data 0; tx_dest_ip 0; tx_dest_port 0; len_err 0; ovf_err 0; pointer such that requester 0 has top priority; counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no tx_end_of_frame emitted; tx_valid SHALL be 0 from the cycle after rst is sampled.

Configuration
REQ-033 GBE_TX_ARB_STATS_EN defined: an additional output pkt_count (32*NUM_REQ) SHALL be present, holding per-requester frames sent; it increments on each emitted tx_end_of_frame (truncated frames included), wraps at 2^32, and resets to 0.
REQ-034 GBE_TX_ARB_STATS_EN undefined: the pkt_count port and its counters SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package gbe_tx_arb_pkg SHALL hold the state enum and the word/IP/port width constants (64/32/16).
REQ-036 Sub-module rr_arbiter (NUM_REQ request vector plus pointer -> one-hot grant) SHALL be instantiated once.

Verification
REQ-037 Requesters 0 and 2 each hold a 4-word packet from the same cycle -> requester 0's frame then requester 2's, each tx_end_of_frame on word 4, dest IP/port per requester.
REQ-038 All 4 requesters continuously valid, 1-word packets, 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-039 tx_afull high for 5 cycles during word 3 of 8 -> req_ready low for those 5 cycles, frame contiguous in order, exactly 8 tx_valid words.
REQ-040 MAX_WORDS=16, 20-word packet -> 16 words out, word 16 with eof, len_err=1, 4 words dropped, next requester granted afterwards.
REQ-041 rst pulsed at word 2 of 6 -> tx_valid 0 from the next cycle, grant 0, errors cleared; the following packet is sent intact from requester 0.
REQ-042 With stats enabled: 3 frames from requester 1 plus tx_overflow pulse -> pkt_count[1]=3, ovf_err=1.
